// File: rtl/ps2_ram_writer.sv
// ps2_ram_writer
//   Receives PS/2 keyboard frames (start, 8 data bits LSB-first, odd parity, stop) and writes
//   each good byte into a 2**ADDR_W x 8 RAM through its address/data/wren write port, at
//   sequential addresses. Producer side of the RAM that feeds the HEX/LEDG display path.
//
// Parameters
//   ADDR_W   RAM address width; depth = 2**ADDR_W
//   TIMEOUT  system clocks without a ps2_clk fall before a partial frame is aborted
//   WRAP     1: address wraps to 0 after the last slot; 0: stop writing and assert o_full
//
// Ports
//   i_clock      system clock
//   i_reset      asynchronous active-low reset
//   i_ps2_clk    PS/2 clock from keyboard (asynchronous)
//   i_ps2_dat    PS/2 data from keyboard (asynchronous)
//   o_address    RAM write address
//   o_data       RAM write data, holds until the next write
//   o_wren       RAM write enable, one-clock pulse
//   o_full       all slots written (WRAP=0 only, otherwise 0)
//   o_frame_err  one-clock pulse on a start, parity, stop or timeout error
//
// Build option
//   PS2_BREAK_FILTER_EN: drop 0xF0 and the byte that follows it, so only make codes are written.

`timescale 1ns / 1ps

module ps2_ram_writer #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned TIMEOUT = 50000,
   parameter int unsigned WRAP    = 1
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_ps2_clk,
   input  logic              i_ps2_dat,
   output logic [ADDR_W-1:0] o_address,
   output logic [7:0]        o_data,
   output logic              o_wren,
   output logic              o_full,
   output logic              o_frame_err
);

   localparam int unsigned       TcntW    = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LastAddr = '1;

   typedef enum logic [2:0] {
      StIdle,
      StData,
      StParity,
      StStop,
      StWrite
   } state_e;

   // Synchronisers and edge detect
   logic r_clk_meta, r_clk_sync, r_clk_prev;
   logic r_dat_meta, r_dat_sync;
   logic w_fall;

   // Receiver state
   state_e     r_state, w_state_d;
   logic [2:0] r_bit_cnt, w_bit_cnt_d;
   logic [7:0] r_shift, w_shift_d;
   logic       r_par, w_par_d;
   logic [TcntW-1:0] r_tcnt;
   logic       w_timeout;
   logic       w_good;
   logic       w_err;
   logic       w_accept;

   // Write port state
   logic [ADDR_W-1:0] r_address;
   logic [7:0]        r_data;
   logic              r_wr_ok;
   logic              r_full;
   logic              r_frame_err;

`ifdef PS2_BREAK_FILTER_EN
   logic r_brk, w_brk_d;
   logic w_is_break;
`endif

   // Flops reset to the idle-high bus level so reset release never looks like a falling edge.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
      end else begin
         r_clk_meta <= i_ps2_clk;
         r_clk_sync <= r_clk_meta;
         r_clk_prev <= r_clk_sync;
         r_dat_meta <= i_ps2_dat;
         r_dat_sync <= r_dat_meta;
      end
   end

   assign w_fall    = r_clk_prev & ~r_clk_sync;
   assign w_timeout = (r_state != StIdle) && (r_tcnt == TcntW'(TIMEOUT));

   // Timeout counter: idle in StIdle, restarted by every sampled edge.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_tcnt <= '0;
      end else if (r_state == StIdle || w_fall || w_timeout) begin
         r_tcnt <= '0;
      end else begin
         r_tcnt <= r_tcnt + TcntW'(1);
      end
   end

   // Next-state logic; a timeout takes priority over an edge in the same clock.
   always_comb begin
      w_state_d   = r_state;
      w_bit_cnt_d = r_bit_cnt;
      w_shift_d   = r_shift;
      w_par_d     = r_par;
      w_good      = 1'b0;
      w_err       = 1'b0;
      if (w_timeout) begin
         w_state_d = StIdle;
         w_err     = 1'b1;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_fall) begin
                  if (!r_dat_sync) begin
                     w_state_d   = StData;
                     w_bit_cnt_d = 3'd0;
                  end else begin
                     w_err = 1'b1;
                  end
               end
            end
            StData: begin
               if (w_fall) begin
                  w_shift_d = {r_dat_sync, r_shift[7:1]};
                  if (r_bit_cnt == 3'd7) begin
                     w_state_d = StParity;
                  end else begin
                     w_bit_cnt_d = r_bit_cnt + 3'd1;
                  end
               end
            end
            StParity: begin
               if (w_fall) begin
                  w_par_d   = r_dat_sync;
                  w_state_d = StStop;
               end
            end
            StStop: begin
               if (w_fall) begin
                  // Good frame: stop bit high and odd parity over data plus parity bit.
                  if (r_dat_sync && (^{r_shift, r_par})) begin
                     w_good    = 1'b1;
                     w_state_d = StWrite;
                  end else begin
                     w_err     = 1'b1;
                     w_state_d = StIdle;
                  end
               end
            end
            StWrite: begin
               w_state_d = StIdle;
            end
            default: begin
               w_state_d = StIdle;
            end
         endcase
      end
   end

`ifdef PS2_BREAK_FILTER_EN
   // 0xF0 arms suppression of the following good byte (the released key code).
   assign w_is_break = (r_shift == 8'hF0);
   assign w_accept   = w_good && !w_is_break && !r_brk && !r_full;

   always_comb begin
      w_brk_d = r_brk;
      if (w_err) begin
         w_brk_d = 1'b0;
      end else if (w_good) begin
         if (w_is_break) begin
            w_brk_d = 1'b1;
         end else if (r_brk) begin
            w_brk_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_brk <= 1'b0;
      end else begin
         r_brk <= w_brk_d;
      end
   end
`else
   assign w_accept = w_good && !r_full;
`endif

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= StIdle;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_par       <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_bit_cnt   <= w_bit_cnt_d;
         r_shift     <= w_shift_d;
         r_par       <= w_par_d;
         r_frame_err <= w_err;
      end
   end

   // Write port. A good frame that is dropped (full or filtered) still passes through StWrite
   // but with r_wr_ok low, so o_data and o_address stay untouched.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_address <= '0;
         r_data    <= 8'h00;
         r_wr_ok   <= 1'b0;
         r_full    <= 1'b0;
      end else begin
         if (w_good) begin
            r_wr_ok <= w_accept;
         end
         if (w_accept) begin
            r_data <= r_shift;
         end
         if (o_wren) begin
            if (WRAP == 0 && r_address == LastAddr) begin
               r_full <= 1'b1;
            end else begin
               r_address <= r_address + 1'b1;
            end
         end
      end
   end

   assign o_address   = r_address;
   assign o_data      = r_data;
   assign o_wren      = (r_state == StWrite) && r_wr_ok;
   assign o_full      = (WRAP == 0) ? r_full : 1'b0;
   assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_ram_writer.sv
`timescale 1ns / 1ps

module tb_ps2_ram_writer;

   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned TO    = 200;
   localparam int unsigned HALF  = 20;

   logic clock   = 1'b0;
   logic reset   = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_dat = 1'b1;

   logic [AW-1:0] addr_w, addr_s;
   logic [7:0]    data_w, data_s;
   logic          wren_w, wren_s, full_w, full_s, err_w, err_s;

   ps2_ram_writer #(.ADDR_W(AW), .TIMEOUT(TO), .WRAP(1)) dut_w (
      .i_clock(clock), .i_reset(reset), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
      .o_address(addr_w), .o_data(data_w), .o_wren(wren_w), .o_full(full_w),
      .o_frame_err(err_w)
   );

   ps2_ram_writer #(.ADDR_W(AW), .TIMEOUT(TO), .WRAP(0)) dut_s (
      .i_clock(clock), .i_reset(reset), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
      .o_address(addr_s), .o_data(data_s), .o_wren(wren_s), .o_full(full_s),
      .o_frame_err(err_s)
   );

   always #10 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Observed activity, sampled away from the active edge
   int act_w[$];
   int act_s[$];
   int err_cnt_w = 0, err_cnt_s = 0, overlap = 0;
   int last_wren_cyc = 0;
   int stop_fall_cyc = 0;

   always @(negedge clock) begin
      if (wren_w) begin
         act_w.push_back({addr_w, data_w});
         last_wren_cyc = cyc;
      end
      if (wren_s) act_s.push_back({addr_s, data_s});
      if (err_w) err_cnt_w++;
      if (err_s) err_cnt_s++;
      if ((wren_w && err_w) || (wren_s && err_s)) overlap++;
   end

   // Reference model: expected writes as {address, byte}
   int exp_w[$];
   int exp_s[$];
   int m_addr_w, m_addr_s, m_err;
   bit m_full_s, m_brk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_addr_w = 0; m_addr_s = 0; m_err = 0; m_full_s = 0; m_brk = 0;
      exp_w.delete(); exp_s.delete(); act_w.delete(); act_s.delete();
      err_cnt_w = 0; err_cnt_s = 0;
   endtask

   task automatic model_good(input logic [7:0] b);
      bit wr = 1;
`ifdef PS2_BREAK_FILTER_EN
      if (b == 8'hF0) begin
         m_brk = 1; wr = 0;
      end else if (m_brk) begin
         m_brk = 0; wr = 0;
      end
`endif
      if (wr) begin
         exp_w.push_back(m_addr_w * 256 + b);
         m_addr_w = (m_addr_w + 1) % DEPTH;
         if (!m_full_s) begin
            exp_s.push_back(m_addr_s * 256 + b);
            if (m_addr_s == DEPTH - 1) m_full_s = 1;
            else m_addr_s++;
         end
      end
   endtask

   task automatic model_err();
      m_err++;
      m_brk = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      repeat (3) @(negedge clock);
      model_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
   endtask

   task automatic ps2_bit(input logic b, input bit is_stop);
      ps2_dat = b;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      if (is_stop) stop_fall_cyc = cyc;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = ~(^b) ^ bad_par;
      ps2_bit(1'b0, 0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
      ps2_bit(par, 0);
      ps2_bit(~bad_stop, 1);
      ps2_dat = 1'b1;
      repeat (8) @(negedge clock);
      if (bad_par || bad_stop) model_err();
      else model_good(b);
   endtask

   task automatic verify(input string tag);
      check({tag, ".nw_w"}, act_w.size(), exp_w.size());
      for (int i = 0; i < exp_w.size(); i++)
         check({tag, ".wr_w"}, (i < act_w.size()) ? act_w[i] : 'x, exp_w[i]);
      check({tag, ".nw_s"}, act_s.size(), exp_s.size());
      for (int i = 0; i < exp_s.size(); i++)
         check({tag, ".wr_s"}, (i < act_s.size()) ? act_s[i] : 'x, exp_s[i]);
      check({tag, ".addr_w"}, addr_w, m_addr_w);
      check({tag, ".addr_s"}, addr_s, m_addr_s);
      check({tag, ".full_w"}, full_w, 0);
      check({tag, ".full_s"}, full_s, m_full_s);
      check({tag, ".err_w"}, err_cnt_w, m_err);
      check({tag, ".err_s"}, err_cnt_s, m_err);
      exp_w.delete(); exp_s.delete(); act_w.delete(); act_s.delete();
   endtask

   initial begin
      #50_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      reset = 1'b0;
      #5;
      check("rst.addr", {addr_w, addr_s}, 0);
      check("rst.data", {data_w, data_s}, 0);
      check("rst.ctl", {wren_w, wren_s, full_w, full_s, err_w, err_s}, 0);
      do_reset();

      // Single make code and write latency
      send_frame(8'h1C, 0, 0);
      check("t1.latency", last_wren_cyc - stop_fall_cyc, 3);
      check("t1.data", data_w, 8'h1C);
      verify("t1");

      // Fill every slot, then one more
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(8'(i), 0, 0);
         verify("t2");
      end
      send_frame(8'h55, 0, 0);
      verify("t2.wrap");

      // Bad parity and bad stop: error, no write
      send_frame(8'h1C, 1, 0);
      verify("t4.par");
      send_frame(8'h3A, 0, 1);
      verify("t4.stop");

      // Timeout during a partial frame, then recovery
      ps2_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 0);
      ps2_dat = 1'b1;
      repeat (TO + 20) @(negedge clock);
      model_err();
      verify("t5.to");
      send_frame(8'h32, 0, 0);
      verify("t5.after");

      // Break-code sequence
      do_reset();
      send_frame(8'h1C, 0, 0);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h1C, 0, 0);
      send_frame(8'h32, 0, 0);
      verify("t6");

      // Random frames with occasional errors
      for (int i = 0; i < 14; i++) begin
         logic [7:0] b;
         bit bp;
         b  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 6) == 0) b = 8'hF0;
         bp = ($urandom_range(0, 4) == 0);
         send_frame(b, bp, 0);
         verify("rnd");
      end

      // Reset mid-frame clears outputs at once
      ps2_bit(1'b0, 0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0);
      reset = 1'b0;
      #1;
      check("mid.addr", {addr_w, addr_s}, 0);
      check("mid.data", {data_w, data_s}, 0);
      check("mid.ctl", {wren_w, wren_s, full_w, full_s, err_w, err_s}, 0);
      do_reset();
      send_frame(8'h2B, 0, 0);
      verify("mid.after");

      check("overlap", overlap, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
